alu_top: RTL and testbench
==========================

Name: alu_top

Overview:
- MIPS-style 32-bit ALU with integrated ALU-control decode.
- Decodes the instruction opcode and R-type function field into an ALU operation, applies it to operands A and B, and registers result plus zero flag.
- Sits in the execute stage; zero feeds branch resolution (beq/bne).

Parameters:
- WIDTH, 32, operand/result width; the decode below is defined for 32 only.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- opcode  input  6  instruction opcode [31:26]
- func_field  input  6  R-type funct [5:0]; ignored when opcode != 0
- A  input  32  operand A (rs)
- B  input  32  operand B (rt or extended immediate)
- result  output  32  registered ALU result
- zero  output  1  registered flag, 1 when the registered result == 0

Behaviour:
- Reset (async, rst=1):
  - result = 0.
  - zero = 1, consistent with result == 0.
  - Overflow, if compiled in, = 0.
- Latency:
  - Combinational decode and compute; result and zero are captured on every rising clk edge.
  - Outputs reflect the inputs sampled at the previous edge, i.e. 1-cycle latency.
  - No enable and no handshake.
- R-type decode (opcode 0x00), by func_field:
  - 0x20 add, 0x21 addu: A+B.
  - 0x22 sub, 0x23 subu: A-B.
  - 0x24 and, 0x25 or, 0x26 xor.
  - 0x27 nor: ~(A|B).
  - 0x2A slt: signed A<B ? 1 : 0.
  - 0x2B sltu: unsigned compare.
  - 0x04 sllv: B << A[4:0].
  - 0x06 srlv: B >> A[4:0], logical.
  - 0x07 srav: B >>> A[4:0], arithmetic.
  - Any other funct: result 0.
- I-type decode (opcode != 0):
  - 0x23 lw, 0x2B sw, 0x08 addi, 0x09 addiu: A+B.
  - 0x04 beq, 0x05 bne: A-B.
  - 0x0A slti: signed compare.
  - 0x0B sltiu: unsigned compare.
  - 0x0C andi, 0x0D ori, 0x0E xori: bitwise ops.
  - 0x0F lui: {B[15:0], 16'h0}.
  - Any other opcode: result 0.
- Arithmetic rules:
  - Add and sub wrap modulo 2^32; carry-out is discarded.
  - Signed and unsigned variants produce identical result bits.
  - slt/sltu results are zero-extended to 32 bits (0x00000001 or 0x00000000).
- Shift boundaries:
  - Shift amount 0 passes B unchanged.
  - Shift amount 31 is the maximum.
  - sra with B[31]=1 fills with ones.
- zero is computed from the next result value and registered with it, so the two are always coherent.
- Reset asserted mid-operation clears the outputs immediately. The first post-reset edge captures the current inputs.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- Defined:
  - Adds output port overflow, 1 bit, registered with result, reset 0.
  - Set on signed overflow for add, addi and sub only: operand signs agree (add) or differ (sub) and the result sign differs from A.
  - addu, addiu, subu, lw, sw, beq, bne and all other operations drive overflow = 0.
  - Result is still written; there is no trap.
- Not defined: port absent, no overflow logic.

Test Plan:
- Reset: assert rst with random inputs -> result=0x00000000, zero=1 immediately, without waiting for a clk edge.
- A=0x2222, B=0x1111, opcode=0x00, funct=0x20 -> after 1 edge result=0x00003333, zero=0. Same inputs with funct=0x24 -> result=0x00000000, zero=1.
- lw (opcode=0x23, funct=0x00), A=0x2222, B=0x1111 -> result=0x00003333, zero=0.
- beq (opcode=0x04), A=B=0x5555 -> result=0, zero=1. Then A=0x5555, B=0x5554 -> result=1, zero=0.
- slt (opcode=0x00, funct=0x2A), A=0x1111, B=0x2222 -> result=1. A=0xFFFFFFFF, B=1: slt -> 1, sltu -> 0.
- Shifts and overflow (ALU_OVERFLOW_EN):
  - srav with B=0x80000000, A=31 -> 0xFFFFFFFF.
  - lui with B=0x1234 -> 0x12340000.
  - add with A=0x7FFFFFFF, B=1 -> result=0x80000000, overflow=1.
  - addu with the same operands -> overflow=0.

Source files
------------

// File: rtl/alu_top.sv
`default_nettype none
// ============================================================================
//  Module      : alu_top
//  Description : MIPS-style execute-stage ALU with built-in ALU-control
//                decode. The opcode (and funct for R-type) selects an
//                operation on A/B; result and zero are registered together.
//  Ports       : clk        - rising-edge clock
//                rst        - asynchronous active-high reset
//                opcode     - instruction opcode [31:26]
//                func_field - R-type funct [5:0], ignored when opcode != 0
//                A, B       - operands (rs, rt / extended immediate)
//                result     - registered ALU result (1-cycle latency)
//                zero       - registered, 1 when result == 0
//                overflow   - registered signed overflow for add/addi/sub
//                             (present only when ALU_OVERFLOW_EN is defined)
//  Options     : `define ALU_OVERFLOW_EN to add the overflow output.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_top #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       func_field,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] result,
`ifdef ALU_OVERFLOW_EN
   output logic             overflow,
`endif
   output logic             zero
);

   // Internal operation encoding produced by the decode stage
   localparam logic [3:0] c_OP_NONE = 4'd0;
   localparam logic [3:0] c_OP_ADD  = 4'd1;
   localparam logic [3:0] c_OP_SUB  = 4'd2;
   localparam logic [3:0] c_OP_AND  = 4'd3;
   localparam logic [3:0] c_OP_OR   = 4'd4;
   localparam logic [3:0] c_OP_XOR  = 4'd5;
   localparam logic [3:0] c_OP_NOR  = 4'd6;
   localparam logic [3:0] c_OP_SLT  = 4'd7;
   localparam logic [3:0] c_OP_SLTU = 4'd8;
   localparam logic [3:0] c_OP_SLL  = 4'd9;
   localparam logic [3:0] c_OP_SRL  = 4'd10;
   localparam logic [3:0] c_OP_SRA  = 4'd11;
   localparam logic [3:0] c_OP_LUI  = 4'd12;

   logic [3:0]       w_op;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic [4:0]       w_shamt;
   logic [WIDTH-1:0] w_next;

   // ------------------------------------------------------------------
   // ALU-control decode
   // ------------------------------------------------------------------
   always_comb begin
      w_op = c_OP_NONE;
      if (opcode == 6'h00) begin
         case (func_field)
            6'h20, 6'h21: w_op = c_OP_ADD;
            6'h22, 6'h23: w_op = c_OP_SUB;
            6'h24:        w_op = c_OP_AND;
            6'h25:        w_op = c_OP_OR;
            6'h26:        w_op = c_OP_XOR;
            6'h27:        w_op = c_OP_NOR;
            6'h2A:        w_op = c_OP_SLT;
            6'h2B:        w_op = c_OP_SLTU;
            6'h04:        w_op = c_OP_SLL;
            6'h06:        w_op = c_OP_SRL;
            6'h07:        w_op = c_OP_SRA;
            default:      w_op = c_OP_NONE;
         endcase
      end else begin
         case (opcode)
            6'h23, 6'h2B, 6'h08, 6'h09: w_op = c_OP_ADD;
            6'h04, 6'h05:               w_op = c_OP_SUB;
            6'h0A:                      w_op = c_OP_SLT;
            6'h0B:                      w_op = c_OP_SLTU;
            6'h0C:                      w_op = c_OP_AND;
            6'h0D:                      w_op = c_OP_OR;
            6'h0E:                      w_op = c_OP_XOR;
            6'h0F:                      w_op = c_OP_LUI;
            default:                    w_op = c_OP_NONE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   assign w_sum   = A + B;      // carry-out intentionally dropped
   assign w_diff  = A - B;
   assign w_shamt = A[4:0];     // variable shifts take the amount from rs

   always_comb begin
      w_next = '0;
      case (w_op)
         c_OP_ADD:  w_next = w_sum;
         c_OP_SUB:  w_next = w_diff;
         c_OP_AND:  w_next = A & B;
         c_OP_OR:   w_next = A | B;
         c_OP_XOR:  w_next = A ^ B;
         c_OP_NOR:  w_next = ~(A | B);
         c_OP_SLT:  w_next = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         c_OP_SLTU: w_next = {{(WIDTH-1){1'b0}}, (A < B)};
         c_OP_SLL:  w_next = B << w_shamt;
         c_OP_SRL:  w_next = B >> w_shamt;
         c_OP_SRA:  w_next = $signed(B) >>> w_shamt;
         c_OP_LUI:  w_next = {B[15:0], {(WIDTH-16){1'b0}}};
         default:   w_next = '0;
      endcase
   end

`ifdef ALU_OVERFLOW_EN
   // Only the trapping forms (add, addi, sub) report overflow; the
   // unsigned forms, address calculations and branch compares do not.
   logic w_chk_add;
   logic w_chk_sub;
   logic w_ovf;

   assign w_chk_add = ((opcode == 6'h00) && (func_field == 6'h20)) || (opcode == 6'h08);
   assign w_chk_sub =  (opcode == 6'h00) && (func_field == 6'h22);

   assign w_ovf = (w_chk_add && (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1]  != A[WIDTH-1])) ||
                  (w_chk_sub && (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]));
`endif

   // ------------------------------------------------------------------
   // Output registers: zero is derived from the same next value so it
   // is always coherent with result.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result   <= '0;
         zero     <= 1'b1;
`ifdef ALU_OVERFLOW_EN
         overflow <= 1'b0;
`endif
      end else begin
         result   <= w_next;
         zero     <= (w_next == '0);
`ifdef ALU_OVERFLOW_EN
         overflow <= w_ovf;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_top
//  Description : Self-checking bench for alu_top. A table of vectors is
//                driven one per cycle; expected values are queued when a
//                vector is driven and popped when the registered output is
//                sampled. Hand-written sequences cover asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_top;

   logic        clk;
   logic        rst;
   logic [5:0]  opcode;
   logic [5:0]  func_field;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] result;
   logic        zero;
   logic        ovf;

   alu_top #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .func_field (func_field),
      .A          (A),
      .B          (B),
      .result     (result),
`ifdef ALU_OVERFLOW_EN
      .overflow   (ovf),
`endif
      .zero       (zero)
   );

`ifndef ALU_OVERFLOW_EN
   assign ovf = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        ov;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        ov;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] res, input logic ov);
      vec_t v;
      v.op = op; v.fn = fn; v.a = a; v.b = b; v.res = res; v.ov = ov;
      return v;
   endfunction

   // Pop one expectation and compare against the current DUT outputs
   task automatic check(input string name);
      exp_t e;
      n_vec++;
      if (sb.size() == 0) begin
         n_miss++;
         $display("FAIL %s: scoreboard empty, result=%h zero=%b", name, result, zero);
      end else begin
         e = sb.pop_front();
         if (result !== e.res || zero !== e.z
`ifdef ALU_OVERFLOW_EN
             || ovf !== e.ov
`endif
            ) begin
            n_miss++;
            $display("FAIL %s: got result=%h zero=%b ovf=%b, expected result=%h zero=%b ovf=%b",
                     name, result, zero, ovf, e.res, e.z, e.ov);
         end
      end
   endtask

   task automatic push_exp(input logic [31:0] res, input logic ov);
      exp_t e;
      e.res = res;
      e.z   = (res == 32'h0);
      e.ov  = ov;
      sb.push_back(e);
   endtask

   task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b);
      opcode = op; func_field = fn; A = a; B = b;
   endtask

   initial begin
      // ---------------- vector table ----------------
      vecs.push_back(mk(6'h00, 6'h20, 32'h00002222, 32'h00001111, 32'h00003333, 1'b0)); // add
      vecs.push_back(mk(6'h00, 6'h24, 32'h00002222, 32'h00001111, 32'h00000000, 1'b0)); // and -> 0
      vecs.push_back(mk(6'h23, 6'h00, 32'h00002222, 32'h00001111, 32'h00003333, 1'b0)); // lw
      vecs.push_back(mk(6'h04, 6'h00, 32'h00005555, 32'h00005555, 32'h00000000, 1'b0)); // beq equal
      vecs.push_back(mk(6'h04, 6'h00, 32'h00005555, 32'h00005554, 32'h00000001, 1'b0)); // beq diff
      vecs.push_back(mk(6'h00, 6'h2A, 32'h00001111, 32'h00002222, 32'h00000001, 1'b0)); // slt
      vecs.push_back(mk(6'h00, 6'h2A, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0)); // slt -1<1
      vecs.push_back(mk(6'h00, 6'h2B, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0)); // sltu
      vecs.push_back(mk(6'h00, 6'h2A, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0)); // slt min<max
      vecs.push_back(mk(6'h00, 6'h2B, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 1'b0)); // sltu
      vecs.push_back(mk(6'h00, 6'h07, 32'h0000001F, 32'h80000000, 32'hFFFFFFFF, 1'b0)); // srav 31
      vecs.push_back(mk(6'h00, 6'h07, 32'h00000004, 32'h70000000, 32'h07000000, 1'b0)); // srav pos
      vecs.push_back(mk(6'h00, 6'h06, 32'h0000001F, 32'h80000000, 32'h00000001, 1'b0)); // srlv 31
      vecs.push_back(mk(6'h00, 6'h06, 32'h00000004, 32'hF0000000, 32'h0F000000, 1'b0)); // srlv logical
      vecs.push_back(mk(6'h00, 6'h04, 32'h00000000, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0)); // sllv 0
      vecs.push_back(mk(6'h00, 6'h04, 32'hFFFFFFFF, 32'h00000001, 32'h80000000, 1'b0)); // sllv uses A[4:0]
      vecs.push_back(mk(6'h0F, 6'h00, 32'h0000DEAD, 32'h00001234, 32'h12340000, 1'b0)); // lui
      vecs.push_back(mk(6'h00, 6'h20, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1)); // add ovf
      vecs.push_back(mk(6'h00, 6'h21, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0)); // addu
      vecs.push_back(mk(6'h00, 6'h20, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1)); // add neg ovf, wrap
      vecs.push_back(mk(6'h08, 6'h00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1)); // addi ovf
      vecs.push_back(mk(6'h09, 6'h00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0)); // addiu
      vecs.push_back(mk(6'h00, 6'h22, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1)); // sub ovf
      vecs.push_back(mk(6'h00, 6'h22, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1)); // sub ovf
      vecs.push_back(mk(6'h00, 6'h23, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0)); // subu
      vecs.push_back(mk(6'h04, 6'h00, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0)); // beq no ovf
      vecs.push_back(mk(6'h05, 6'h00, 32'h00000010, 32'h00000003, 32'h0000000D, 1'b0)); // bne
      vecs.push_back(mk(6'h2B, 6'h00, 32'h00000100, 32'hFFFFFFFC, 32'h000000FC, 1'b0)); // sw
      vecs.push_back(mk(6'h00, 6'h27, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0)); // nor
      vecs.push_back(mk(6'h00, 6'h26, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0)); // xor
      vecs.push_back(mk(6'h00, 6'h25, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0)); // or
      vecs.push_back(mk(6'h00, 6'h3F, 32'h12345678, 32'h11111111, 32'h00000000, 1'b0)); // bad funct
      vecs.push_back(mk(6'h3F, 6'h20, 32'h12345678, 32'h11111111, 32'h00000000, 1'b0)); // bad opcode
      vecs.push_back(mk(6'h0A, 6'h00, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001, 1'b0)); // slti
      vecs.push_back(mk(6'h0B, 6'h00, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0)); // sltiu
      vecs.push_back(mk(6'h0C, 6'h20, 32'hFFFF1234, 32'h0000FFFF, 32'h00001234, 1'b0)); // andi, funct ignored
      vecs.push_back(mk(6'h0D, 6'h00, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0)); // ori
      vecs.push_back(mk(6'h0E, 6'h00, 32'h0000FFFF, 32'h00000F0F, 32'h0000F0F0, 1'b0)); // xori

      // ---------------- initial reset ----------------
      rst = 1'b1;
      drive(6'h00, 6'h20, $urandom, $urandom);
      #2;
      push_exp(32'h0, 1'b0);
      check("reset_initial");
      @(posedge clk); #1;
      push_exp(32'h0, 1'b0);
      check("reset_held");
      @(negedge clk);
      rst = 1'b0;

      // ---------------- table, one vector per cycle ----------------
      foreach (vecs[i]) begin
         drive(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b);
         push_exp(vecs[i].res, vecs[i].ov);
         @(posedge clk); #1;
         check($sformatf("vec%0d op=%h fn=%h", i, vecs[i].op, vecs[i].fn));
         @(negedge clk);
      end

      // ---------------- async reset mid-operation ----------------
      drive(6'h00, 6'h20, 32'h7FFFFFFF, 32'h00000001);  // leaves nonzero result / ovf
      push_exp(32'h80000000, 1'b1);
      @(posedge clk); #1;
      check("pre_reset_add");
      #2;
      drive(6'h00, 6'h20, $urandom | 32'h1, 32'h0);      // nonzero random sum
      rst = 1'b1;
      #1;                                                 // well before next edge
      push_exp(32'h0, 1'b0);
      check("async_reset_immediate");
      @(negedge clk);
      rst = 1'b0;
      drive(6'h00, 6'h20, 32'h00002222, 32'h00001111);
      #1;
      push_exp(32'h0, 1'b0);
      check("reset_release_no_edge");
      push_exp(32'h00003333, 1'b0);
      @(posedge clk); #1;
      check("first_edge_after_reset");

      // back-to-back: outputs follow previous-edge inputs
      @(negedge clk);
      drive(6'h00, 6'h22, 32'h5, 32'h5);
      push_exp(32'h0, 1'b0);
      @(posedge clk); #1;
      check("b2b_sub_zero");
      drive(6'h00, 6'h22, 32'h5, 32'h3);
      #2;
      push_exp(32'h0, 1'b0);
      check("b2b_hold_until_edge");
      push_exp(32'h2, 1'b0);
      @(posedge clk); #1;
      check("b2b_sub_two");

      if (sb.size() != 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
